// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared funct3 width codes and responder FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Load/store bus between the datapath (master) and dmem (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;

    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        fault;

    modport master (
        output req, we, funct3, addr, wdata,
        input  rdata, busy, done, fault
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output rdata, busy, done, fault
    );

endinterface
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_align
// Description : Byte enables, store lane replication and load extract/extend.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_we,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_illegal,
    output logic        o_misalign
);

    logic [1:0]  w_off;
    logic [31:0] w_lane;
    logic        w_legal_load;
    logic        w_legal_store;

    // Offending low bits are dropped so misaligned accesses snap to alignment.
    always_comb begin
        w_off = i_offset;
        case (i_funct3[1:0])
            2'b01:   w_off = {i_offset[1], 1'b0};
            2'b10:   w_off = 2'b00;
            default: w_off = i_offset;
        endcase
    end

    always_comb begin
        w_legal_load  = 1'b0;
        w_legal_store = 1'b0;
        case (i_funct3)
            F3_B, F3_H, F3_W: begin
                w_legal_load  = 1'b1;
                w_legal_store = 1'b1;
            end
            F3_BU, F3_HU: w_legal_load = 1'b1;
            default: ;
        endcase
    end

    assign o_illegal  = i_we ? ~w_legal_store : ~w_legal_load;
    assign o_misalign = ((i_funct3[1:0] == 2'b01) && i_offset[0]) ||
                        ((i_funct3 == F3_W) && (i_offset != 2'b00));

    // Store data is replicated across lanes; the byte enables pick the target.
    always_comb begin
        o_be    = 4'b0000;
        o_wword = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << w_off;
                o_wword = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << w_off;
                o_wword = {2{i_wdata[15:0]}};
            end
            2'b10: begin
                o_be    = 4'b1111;
                o_wword = i_wdata;
            end
            default: o_be = 4'b0000;
        endcase
    end

    assign w_lane = i_rword >> {w_off, 3'b000};

    always_comb begin
        o_rdata = 32'h0;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
            F3_H:    o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
            F3_W:    o_rdata = w_lane;
            F3_BU:   o_rdata = {24'h0, w_lane[7:0]};
            F3_HU:   o_rdata = {16'h0, w_lane[15:0]};
            default: o_rdata = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder with configurable wait states.
//               DMEM_MISALIGN_TRAP_EN enables the sticky misalign/illegal fault.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int         c_depth   = 1 << ADDR_W;
    localparam logic [3:0] c_latency = 4'(LATENCY);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;

    logic [ADDR_W+1:0] r_addr;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [31:0]       r_wdata;
    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [c_depth];

    logic [ADDR_W+1:0] w_addr;
    logic              w_we;
    logic [2:0]        w_funct3;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_widx;
    logic [31:0]       w_rword;
    logic [3:0]        w_be;
    logic [31:0]       w_wword;
    logic [31:0]       w_load;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_blocked;
    logic              w_to_resp;

    // In IDLE the live bus is used so a zero-latency access reads on the accept edge.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_addr   = bus.addr[ADDR_W+1:0];
            w_we     = bus.we;
            w_funct3 = bus.funct3;
            w_wdata  = bus.wdata;
        end else begin
            w_addr   = r_addr;
            w_we     = r_we;
            w_funct3 = r_funct3;
            w_wdata  = r_wdata;
        end
    end

    assign w_widx  = w_addr[ADDR_W+1:2];
    assign w_rword = r_mem[w_widx];

    dmem_align u_align (
        .i_funct3   (w_funct3),
        .i_we       (w_we),
        .i_offset   (w_addr[1:0]),
        .i_wdata    (w_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_load),
        .o_illegal  (w_illegal),
        .o_misalign (w_misalign)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_fault;

    assign w_blocked = w_illegal | w_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_to_resp && (w_illegal || w_misalign)) begin
            r_fault <= 1'b1;
        end
    end

    assign bus.fault = r_fault;
`else
    logic w_unused_misalign;

    assign w_blocked         = w_illegal;
    assign w_unused_misalign = w_misalign;
    assign bus.fault         = 1'b0;
`endif

    generate
        if (ADDR_W < 30) begin : g_addr_sink
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^bus.addr[31:ADDR_W+2];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_cnt_nxt   = c_latency;
                    w_state_nxt = (c_latency != 4'd0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_to_resp = (w_state_nxt == ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_to_resp;
            // Load data is presented together with the done pulse.
            if (w_to_resp && !w_we) begin
                r_rdata <= w_blocked ? 32'h0 : w_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && bus.req) begin
            r_addr   <= bus.addr[ADDR_W+1:0];
            r_we     <= bus.we;
            r_funct3 <= bus.funct3;
            r_wdata  <= bus.wdata;
        end
    end

    // The array commits on the edge that leaves RESP, so a reset in RESP drops it.
    always_ff @(posedge clk) begin
        if (!rst && r_state == ST_RESP && r_we && !w_blocked) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_widx][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RISC-V core: the memory end of the datapath's load/store interface.
- Accepts the ALU-computed address, register store data and funct3 width code; performs byte/half/word reads and writes on an internal word array.
- Returns load data to the datapath write-back path (the data_m input) after a configurable number of wait states.
- Raises busy so control logic can drop en_fetch and hold the PC until the access completes.

Parameters:
- ADDR_W, 10, word-address width; the array holds 2**ADDR_W 32-bit words.
- LATENCY, 1, number of wait-state cycles between acceptance and completion (0..15).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- req  input  1  access request, sampled only in IDLE
- we  input  1  1 = store, 0 = load
- funct3  input  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- addr  input  32  byte address (alu_result)
- wdata  input  32  store data (Rdata2)
- rdata  output  32  load result, extended to 32 bits; drives data_m
- busy  output  1  access in progress; control deasserts en_fetch while high
- done  output  1  one-cycle completion pulse
- fault  output  1  sticky misalign/illegal-width flag (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; synchronous active-high rst; all state changes on the rising edge of clk.
- Reset values: rdata=0, busy=0, done=0, fault=0, FSM=IDLE, counter=0. Memory contents are not cleared.
- FSM states are IDLE, WAIT and RESP.
- IDLE: when req=1, latch addr, we, funct3 and wdata; load counter with LATENCY. Next state is WAIT if LATENCY>0, else RESP.
- WAIT: decrement the counter each cycle; when it reaches 1, go to RESP.
- RESP: perform the array access this cycle; done=1 for exactly this cycle; next state is IDLE.
- busy is registered: high in WAIT and RESP, low in IDLE. The done pulse coincides with the last busy cycle.
- Latency: done is asserted LATENCY+1 cycles after the edge that samples req.
- req is ignored outside IDLE; there is no queueing.
- Back-to-back: req held high in the cycle after RESP starts a new access.
- Word index = latched addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size.
- Stores use byte enables derived from funct3 and addr[1:0]:
  - SB writes byte addr[1:0].
  - SH writes bytes {addr[1],0} and {addr[1],1}.
  - SW writes all four bytes.
  - Bytes not enabled are unchanged.
- Loads select a byte, half or word the same way, then:
  - sign-extend for 000/001;
  - zero-extend for 100/101;
  - pass 010 through unchanged.
- rdata updates on the RESP edge for loads only, and holds its value until the next completed load. Stores leave rdata unchanged.
- Illegal funct3 (011, 110, 111, or 1xx with we=1): no array write; a load returns rdata=0; done still pulses.
- Store-then-load to the same address: the load returns the newly written data (the write happens in the earlier RESP).
- rst during WAIT or RESP: return to IDLE immediately; a pending store is dropped; done is not pulsed.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword access with addr[0]=1, word access with addr[1:0]!=0, or illegal funct3 sets fault=1 at RESP.
  - A store is suppressed; a load returns rdata=0.
  - fault stays set until rst.
- Undefined:
  - Misaligned accesses force the low address bits to alignment (the offending bits are treated as 0).
  - fault is tied to 0.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 width constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the FSM state encoding (IDLE/WAIT/RESP).
- One sub-module, dmem_align: combinational byte-enable, store-lane shifting, and load extract/extend logic.
- The FSM, counter and array stay in the top module.

Test Plan:
- SW addr=0x00000010, wdata=0xDEADBEEF, LATENCY=1, then LW same address → done exactly 2 cycles after each req; rdata=0xDEADBEEF; busy high for 2 cycles per access.
- Following the word above, SB addr=0x11, wdata=0x000000A5; then LB 0x11 → rdata=0xFFFFFFA5; LBU 0x11 → 0x000000A5; LW 0x10 → 0xDEADA5EF.
- SH addr=0x22, wdata=0x00008001; then LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001; LW 0x20 upper half = 0x8001.
- Reset mid-operation: issue SW to 0x30 with LATENCY=3, assert rst in the second WAIT cycle → no done pulse, busy=0 after reset; subsequent LW 0x30 returns the prior contents.
- Wrap and illegal width: with ADDR_W=10, SW to 0x1000 then LW 0x0 → same word. Load with funct3=011 → rdata=0, done pulses, no write.
- With DMEM_MISALIGN_TRAP_EN: LW addr=0x13 → fault=1, rdata=0. Without it: LW 0x13 → returns the word at 0x10, fault=0.
